// File: rtl/fifo_pkt_tx.sv
// Packetiser: drains a show-ahead FIFO into HEAD/BODY/TAIL flits through a single output register.
// Optional idle-timeout start condition is enabled with `define PKT_TX_TIMEOUT_EN.
module fifo_pkt_tx #(
  parameter int BW      = 8,
  parameter int LGFLEN  = 4,
  parameter int PKT_LEN = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [BW-1:0]     i_data,
  input  logic              i_empty,
  input  logic [LGFLEN:0]   i_fill,
  output logic              o_rd,
  input  logic [3:0]        i_dest,
  output logic [BW+1:0]     o_flit,
  output logic              o_flit_valid,
  input  logic              i_flit_ready,
  output logic              o_busy,
  output logic [7:0]        o_pkt_cnt,
  output logic              o_dbg_state
);

  // Handshake: a flit transfers on any rising edge where o_flit_valid=1 and
  // i_flit_ready=1; the output register may only load when it is empty or
  // transferring, so a stalled flit never changes.
  typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b10;

  state_t          state_q, state_d;
  logic [3:0]      rem_q, rem_d;
  logic [BW+1:0]   flit_q, flit_d;
  logic            flit_valid_q, flit_valid_d;
  logic [7:0]      pkt_cnt_q, pkt_cnt_d;

  logic            reg_free;
  logic            start;
  logic            head_load;
  logic [31:0]     fill_w;
  logic [3:0]      len;
  logic [BW-1:0]   hdr;

  assign reg_free  = !flit_valid_q || i_flit_ready;
  assign fill_w    = 32'(i_fill);
  assign len       = (fill_w >= 32'(PKT_LEN)) ? 4'(PKT_LEN) : 4'(i_fill);
  assign head_load = (state_q == IDLE) && reg_free && start;

  always_comb begin
    hdr      = '0;
    hdr[7:0] = {i_dest, len};
  end

`ifdef PKT_TX_TIMEOUT_EN
  logic [7:0] idle_cnt_q, idle_cnt_d;

  assign start = (fill_w >= 32'(PKT_LEN)) ||
                 (!i_empty && (idle_cnt_q >= 8'(TIMEOUT)));

  // Counts idle cycles spent holding a short packet; saturates so a late burst still waits at most TIMEOUT.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (i_empty || head_load) begin
      idle_cnt_d = '0;
    end else if ((state_q == IDLE) && (fill_w > 32'd0) && (fill_w < 32'(PKT_LEN)) &&
                 (idle_cnt_q < 8'(TIMEOUT))) begin
      idle_cnt_d = idle_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) idle_cnt_q <= '0;
    else          idle_cnt_q <= idle_cnt_d;
  end
`else
  assign start = !i_empty;
`endif

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    flit_d       = flit_q;
    flit_valid_d = flit_valid_q;
    o_rd         = 1'b0;
    if (reg_free) flit_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (head_load) begin
          flit_d       = {T_HEAD, hdr};
          flit_valid_d = 1'b1;
          rem_d        = len;
          state_d      = BODY;
        end
      end
      BODY: begin
        if (reg_free) begin
          o_rd         = 1'b1;
          flit_valid_d = 1'b1;
          flit_d       = {(rem_q == 4'd1) ? T_TAIL : T_BODY, i_data};
          rem_d        = rem_q - 4'd1;
          if (rem_q == 4'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (flit_valid_q && i_flit_ready && (flit_q[BW+1:BW] == T_TAIL))
      pkt_cnt_d = pkt_cnt_q + 8'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
      pkt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      flit_q       <= flit_d;
      flit_valid_q <= flit_valid_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  assign o_flit       = flit_q;
  assign o_flit_valid = flit_valid_q;
  assign o_busy       = (state_q == BODY);
  assign o_pkt_cnt    = pkt_cnt_q;
  assign o_dbg_state  = state_q;

endmodule
